// File: rtl/csa_resolver_pkg.sv
// Shared definitions for the carry-save resolver: FSM states, slice sizing
// helpers and the legality check applied when the top elaborates.
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned CHUNK_DEFAULT = 3;

  function automatic int unsigned slice_count(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned chunk);
    return (chunk != 0) && (width != 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/csa_slice_adder.sv
// CHUNK-bit ripple adder slice built from single-bit full adders; the
// resolver reuses one instance for every slice of the operand.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module csa_slice_adder
  import csa_resolver_pkg::*;
#(
  parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    Full_Adder u_fa (
      .a   (a[gi]),
      .b   (b[gi]),
      .cin (w_c[gi]),
      .sum (sum[gi]),
      .cout(w_c[gi+1])
    );
  end

  assign cout = w_c[CHUNK];

endmodule

// File: rtl/csa_resolver.sv
// Iterative carry-propagate back end: resolves a (sum, carry) pair into a
// binary result one CHUNK-bit slice per clock, with valid/ready on both sides.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
);

  localparam int unsigned N    = slice_count(WIDTH, CHUNK);
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("csa_resolver: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_next;
  // A = {1'b0, s_in}: its top bit is always zero and never reaches a slice,
  // so only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH:0]   r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH+1:0] r_result;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_last    = (r_idx == LAST);
  assign w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_slice = r_b[r_idx*CHUNK +: CHUNK];

  csa_slice_adder #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a   (w_a_slice),
    .b   (w_b_slice),
    .cin (r_carry),
    .sum (w_sum),
    .cout(w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= s_in;
      r_b     <= {c_in, 1'b0};
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_result[r_idx*CHUNK +: CHUNK] <= w_sum;
      r_carry                        <= w_cout;
      if (w_last) begin
        // B's top bit has no partner in A, so it folds into the final carry.
        r_result[WIDTH]   <= r_b[WIDTH] ^ w_cout;
        r_result[WIDTH+1] <= r_b[WIDTH] & w_cout;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: vector table, back-pressure, reset
// mid-operation and back-to-back streaming against an arithmetic model.
module tb_csa_resolver;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned CHUNK = 3;
  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned RW    = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] c_in;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_resolver #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_in     (s_in),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] s,
                                          input logic [WIDTH-1:0] c);
    int unsigned v;
    v = int'(s) + 2 * int'(c);
    return v[RW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [RW-1:0]    exp;
  } vec_t;

  vec_t vecs[12];

  logic [RW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            outs   = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      outs++;
      if (exp_q.size() == 0) begin
        check("b2b extra output", 1, 0);
      end else begin
        check("b2b result", result, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input string tag);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " in_ready before accept"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                        input logic [RW-1:0] exp, input int hold,
                        input string tag);
    int lat;
    wait_ready(tag);
    s_in     = s;
    c_in     = c;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // garbage while busy must be ignored
    s_in = WIDTH'($urandom);
    c_in = WIDTH'($urandom);
    lat  = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, lat, N);
    check({tag, " result"}, result, exp);
    check({tag, " in_ready in DONE"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held result"}, result, exp);
      check({tag, " held out_valid"}, out_valid, 1);
      check({tag, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 0);
    check({tag, " in_ready after handshake"}, in_ready, 1);
    check({tag, " result kept in IDLE"}, result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int last_acc;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    vecs[0] = '{s: 12'h000, c: 12'h000, exp: 14'h0000};
    vecs[1] = '{s: 12'hFFF, c: 12'hFFF, exp: 14'h2FFD};
    vecs[2] = '{s: 12'h555, c: 12'h2AA, exp: 14'h0AA9};
    vecs[3] = '{s: 12'hFFF, c: 12'h000, exp: 14'h0FFF};
    vecs[4] = '{s: 12'h000, c: 12'hFFF, exp: 14'h1FFE};
    vecs[5] = '{s: 12'h800, c: 12'h800, exp: 14'h1800};
    for (int i = 6; i < 12; i++) begin
      vecs[i].s   = WIDTH'($urandom);
      vecs[i].c   = WIDTH'($urandom);
      vecs[i].exp = model(vecs[i].s, vecs[i].c);
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    c_in      = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].s, vecs[i].c, vecs[i].exp, 0, $sformatf("vec%0d", i));
    end

    run_op(12'h123, 12'h001, 14'h0125, 5, "backpressure");

    wait_ready("midrst");
    s_in     = 12'hFFF;
    c_in     = 12'hFFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst result", result, 0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst no out_valid pulse", pulses, 0);
    run_op(12'h001, 12'h001, 14'h0003, 0, "after_rst");

    mon_en    = 1'b1;
    out_ready = 1'b1;
    last_acc  = 0;
    for (int i = 0; i < 16; i++) begin
      s        = WIDTH'($urandom);
      c        = WIDTH'($urandom);
      s_in     = s;
      c_in     = c;
      in_valid = 1'b1;
      wait_ready("b2b");
      exp_q.push_back(model(s, c));
      if (i > 0) begin
        check("b2b accept spacing",
              ((cyc - last_acc) >= int'(N + 1)) && ((cyc - last_acc) <= int'(N + 2)), 1);
      end
      last_acc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (N + 6) @(negedge clk);
    check("b2b output count", outs, 16);
    check("b2b queue drained", exp_q.size(), 0);
    mon_en    = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
